// File: rtl/id_pipe.sv
// id_pipe: RV32I instruction-decode pipeline stage.
// Decodes the incoming instruction, reads and forwards register operands,
// and stalls one cycle on a load-use hazard. Produces a registered bundle
// on a valid/ready handshake.
// Ports:
//   clk, rst           clock, async active-high reset
//   in_valid_i/_ready_o fetch-side handshake; inst_i, inst_addr_i
//   rs1/rs2_addr_o      register-file read addresses (combinational)
//   rs1/rs2_data_i      register-file read data
//   fwd_wen/rd/data_i   forwarding channels, index 0 youngest
//   ex_is_load_i/ex_rd_i EX-stage load info for hazard detection
//   flush_i             discard held and incoming instruction
//   out_valid_o/ready_i EX-side handshake; registered bundle outputs
module id_pipe #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             inst_i,
  input  logic [31:0]             inst_addr_i,
  output logic [4:0]              rs1_addr_o,
  output logic [4:0]              rs2_addr_o,
  input  logic [XLEN-1:0]         rs1_data_i,
  input  logic [XLEN-1:0]         rs2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wen_i,
  input  logic [5*NUM_FWD-1:0]    fwd_rd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
  input  logic                    ex_is_load_i,
  input  logic [4:0]              ex_rd_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [31:0]             inst_o,
  output logic [31:0]             inst_addr_o,
  output logic [XLEN-1:0]         op1_o,
  output logic [XLEN-1:0]         op2_o,
  output logic [XLEN-1:0]         imm_o,
  output logic [4:0]              rd_addr_o,
  output logic                    reg_wen_o,
  output logic                    illegal_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] SEL1_RS = 2'd0, SEL1_PC = 2'd1, SEL1_ZERO = 2'd2;
  localparam logic [1:0] SEL2_RS = 2'd0, SEL2_IMM = 2'd1, SEL2_FOUR = 2'd2;

  logic [6:0]        w_opc;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [4:0]        w_rd;
  logic              w_use_rs1, w_use_rs2, w_writes_rd, w_illegal, w_wen;
  logic [1:0]        w_op1_sel, w_op2_sel;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]   w_imm, w_pc, w_rs1_val, w_rs2_val, w_op1, w_op2;
  logic              w_hazard;

  assign w_opc = inst_i[6:0];
  assign w_f3  = inst_i[14:12];
  assign w_f7  = inst_i[31:25];
  assign w_rd  = inst_i[11:7];

  always_comb begin
    w_use_rs1   = 1'b0;
    w_use_rs2   = 1'b0;
    w_writes_rd = 1'b0;
    w_illegal   = 1'b0;
    w_imm32     = '0;
    w_op1_sel   = SEL1_RS;
    w_op2_sel   = SEL2_IMM;
    case (w_opc)
      OPC_LUI: begin
        w_imm32 = {inst_i[31:12], 12'b0};
        w_writes_rd = 1'b1;
        w_op1_sel = SEL1_ZERO;
      end
      OPC_AUIPC: begin
        w_imm32 = {inst_i[31:12], 12'b0};
        w_writes_rd = 1'b1;
        w_op1_sel = SEL1_PC;
      end
      OPC_JAL: begin
        w_imm32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
        w_writes_rd = 1'b1;
        w_op1_sel = SEL1_PC;
        w_op2_sel = SEL2_FOUR;
      end
      OPC_JALR: begin
        w_imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        w_use_rs1 = 1'b1;
        w_writes_rd = 1'b1;
        w_op1_sel = SEL1_PC;
        w_op2_sel = SEL2_FOUR;
        w_illegal = (w_f3 != 3'd0);
      end
      OPC_BRANCH: begin
        w_imm32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_op2_sel = SEL2_RS;
        w_illegal = (w_f3 == 3'd2) || (w_f3 == 3'd3);
      end
      OPC_LOAD: begin
        w_imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        w_use_rs1 = 1'b1;
        w_writes_rd = 1'b1;
        w_illegal = (w_f3 == 3'd3) || (w_f3 >= 3'd6);
      end
      OPC_STORE: begin
        w_imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_op2_sel = SEL2_RS;
        w_illegal = (w_f3 > 3'd2);
      end
      OPC_OPIMM: begin
        w_imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        w_use_rs1 = 1'b1;
        w_writes_rd = 1'b1;
        // shift-immediates reuse the upper immediate bits as funct7
        if (w_f3 == 3'd1) w_illegal = (w_f7 != 7'h00);
        else if (w_f3 == 3'd5) w_illegal = (w_f7 != 7'h00) && (w_f7 != 7'h20);
      end
      OPC_OP: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_writes_rd = 1'b1;
        w_op2_sel = SEL2_RS;
        w_illegal = !((w_f7 == 7'h00) ||
                      ((w_f7 == 7'h20) && ((w_f3 == 3'd0) || (w_f3 == 3'd5))));
      end
      OPC_MISC:   w_illegal = (w_f3 > 3'd1);
      OPC_SYSTEM: w_illegal = (w_f3 != 3'd0);
      default:    w_illegal = 1'b1;
    endcase
  end

  assign w_imm      = XLEN'(w_imm32);
  assign w_pc       = XLEN'(inst_addr_i);
  assign w_wen      = w_writes_rd && (w_rd != 5'd0) && !w_illegal;
  assign rs1_addr_o = w_use_rs1 ? inst_i[19:15] : 5'd0;
  assign rs2_addr_o = w_use_rs2 ? inst_i[24:20] : 5'd0;

  // Walk from oldest to youngest so the lowest-index match wins.
  always_comb begin
    w_rs1_val = rs1_data_i;
    w_rs2_val = rs2_data_i;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_wen_i[i] && (fwd_rd_i[5*i +: 5] == rs1_addr_o))
        w_rs1_val = fwd_data_i[XLEN*i +: XLEN];
      if (fwd_wen_i[i] && (fwd_rd_i[5*i +: 5] == rs2_addr_o))
        w_rs2_val = fwd_data_i[XLEN*i +: XLEN];
    end
    if (rs1_addr_o == 5'd0) w_rs1_val = '0;
    if (rs2_addr_o == 5'd0) w_rs2_val = '0;
  end

  always_comb begin
    w_op1 = w_rs1_val;
    if (w_op1_sel == SEL1_PC)        w_op1 = w_pc;
    else if (w_op1_sel == SEL1_ZERO) w_op1 = '0;
    w_op2 = w_imm;
    if (w_op2_sel == SEL2_RS)        w_op2 = w_rs2_val;
    else if (w_op2_sel == SEL2_FOUR) w_op2 = XLEN'(4);
  end

  // Unused rs addresses are already forced to 0, so ex_rd_i != 0 excludes them.
  assign w_hazard   = in_valid_i && ex_is_load_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == rs1_addr_o) || (ex_rd_i == rs2_addr_o));
  assign in_ready_o = (!out_valid_o || out_ready_i) && !w_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      inst_o      <= 32'h0000_0013;
      inst_addr_o <= '0;
      op1_o       <= '0;
      op2_o       <= '0;
      imm_o       <= '0;
      rd_addr_o   <= '0;
      reg_wen_o   <= 1'b0;
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      out_valid_o <= 1'b1;
      inst_o      <= inst_i;
      inst_addr_o <= inst_addr_i;
      op1_o       <= w_op1;
      op2_o       <= w_op2;
      imm_o       <= w_imm;
      rd_addr_o   <= w_wen ? w_rd : 5'd0;
      reg_wen_o   <= w_wen;
      illegal_o   <= w_illegal;
    end else if (out_ready_i) begin
      // consumed with nothing new (covers the load-use bubble)
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
module tb_id_pipe;

  typedef struct {
    logic [31:0] inst, addr, op1, op2, imm;
    logic [4:0]  rd;
    logic        wen, ill, chk_ops, chk_imm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_i = 1'b0, in_ready_o;
  logic [31:0] inst_i = 32'h0, inst_addr_i = 32'h0;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_data_i = 32'h0, rs2_data_i = 32'h0;
  logic [1:0]  fwd_wen_i = 2'b00;
  logic [9:0]  fwd_rd_i = 10'h0;
  logic [63:0] fwd_data_i = 64'h0;
  logic        ex_is_load_i = 1'b0;
  logic [4:0]  ex_rd_i = 5'd0;
  logic        flush_i = 1'b0;
  logic        out_valid_o, out_ready_i = 1'b1;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o, imm_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o, illegal_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_pipe #(.XLEN(32), .NUM_FWD(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .fwd_wen_i(fwd_wen_i), .fwd_rd_i(fwd_rd_i), .fwd_data_i(fwd_data_i),
    .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .op1_o(op1_o), .op2_o(op2_o), .imm_o(imm_o),
    .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o), .illegal_o(illegal_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] inst, addr, op1, op2, imm,
                              input logic [4:0] rd, input logic wen, ill, chk_ops, chk_imm);
    exp_t e;
    e.inst = inst; e.addr = addr; e.op1 = op1; e.op2 = op2; e.imm = imm;
    e.rd = rd; e.wen = wen; e.ill = ill; e.chk_ops = chk_ops; e.chk_imm = chk_imm;
    return e;
  endfunction

  // Scoreboard consumer: every handshaken bundle is compared to the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check_val("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("out_inst", inst_o, e.inst);
        check_val("out_addr", inst_addr_o, e.addr);
        check_val("out_rd", {27'd0, rd_addr_o}, {27'd0, e.rd});
        check_val("out_wen", {31'd0, reg_wen_o}, {31'd0, e.wen});
        check_val("out_ill", {31'd0, illegal_o}, {31'd0, e.ill});
        if (e.chk_ops) begin
          check_val("out_op1", op1_o, e.op1);
          check_val("out_op2", op2_o, e.op2);
        end
        if (e.chk_imm) check_val("out_imm", imm_o, e.imm);
      end
    end
  end

  // Drive one instruction at posedge+1, check read addresses/ready at negedge.
  task automatic send(input logic [31:0] inst, addr, r1d, r2d,
                      input logic [4:0] e_rs1a, e_rs2a, input exp_t e);
    inst_i = inst; inst_addr_i = addr; rs1_data_i = r1d; rs2_data_i = r2d;
    in_valid_i = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    check_val("rs1_addr", {27'd0, rs1_addr_o}, {27'd0, e_rs1a});
    check_val("rs2_addr", {27'd0, rs2_addr_o}, {27'd0, e_rs2a});
    check_val("in_ready", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check_val("rst_inst", inst_o, 32'h0000_0013);
    check_val("rst_op1", op1_o, 32'd0);
    check_val("rst_imm", imm_o, 32'd0);
    check_val("rst_wen", {31'd0, reg_wen_o}, 32'd0);
    check_val("rst_ill", {31'd0, illegal_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADDI x1,x0,5
    send(32'h00500093, 32'h100, 32'hAAAA, 32'hBBBB, 5'd0, 5'd0,
         mk(32'h00500093, 32'h100, 32'd0, 32'd5, 32'd5, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1));
    // ADD x3,x1,x2: both channels hit rs1, youngest (ch0) wins
    fwd_wen_i = 2'b11; fwd_rd_i = {5'd1, 5'd1}; fwd_data_i = {32'd9, 32'd7};
    send(32'h002081B3, 32'h104, 32'd100, 32'd3, 5'd1, 5'd2,
         mk(32'h002081B3, 32'h104, 32'd7, 32'd3, 32'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0));
    // ch0 disabled, ch1 forwards rs2
    fwd_wen_i = 2'b10; fwd_rd_i = {5'd2, 5'd1};
    send(32'h002081B3, 32'h108, 32'd11, 32'd3, 5'd1, 5'd2,
         mk(32'h002081B3, 32'h108, 32'd11, 32'd9, 32'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0));
    // a producer targeting x0 must never reach an x0 read
    fwd_wen_i = 2'b01; fwd_rd_i = {5'd0, 5'd0}; fwd_data_i = {32'h55, 32'h55};
    send(32'h00500093, 32'h10C, 32'h77, 32'h0, 5'd0, 5'd0,
         mk(32'h00500093, 32'h10C, 32'd0, 32'd5, 32'd5, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1));
    fwd_wen_i = 2'b00;
    // LUI x5,0x12345
    send(32'h123452B7, 32'h110, 32'h1, 32'h2, 5'd0, 5'd0,
         mk(32'h123452B7, 32'h110, 32'd0, 32'h12345000, 32'h12345000, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1));
    // JAL x1,+8
    send(32'h008000EF, 32'h200, 32'h1, 32'h2, 5'd0, 5'd0,
         mk(32'h008000EF, 32'h200, 32'h200, 32'd4, 32'd8, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1));
    // BEQ x1,x2,-8
    send(32'hFE208CE3, 32'h204, 32'h11, 32'h22, 5'd1, 5'd2,
         mk(32'hFE208CE3, 32'h204, 32'h11, 32'h22, 32'hFFFFFFF8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    // SW x2,-4(x1)
    send(32'hFE20AE23, 32'h208, 32'h33, 32'h44, 5'd1, 5'd2,
         mk(32'hFE20AE23, 32'h208, 32'h33, 32'h44, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    // AUIPC x7,1
    send(32'h00001397, 32'h20C, 32'h1, 32'h2, 5'd0, 5'd0,
         mk(32'h00001397, 32'h20C, 32'h20C, 32'h1000, 32'h1000, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1));
    // JALR x0,0(x1): rd=x0 gives no writeback
    send(32'h00008067, 32'h210, 32'h55, 32'h2, 5'd1, 5'd0,
         mk(32'h00008067, 32'h210, 32'h210, 32'd4, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    // SRAI x1,x1,3: rs2 field holds shamt but is not a register read
    send(32'h4030D093, 32'h214, 32'h66, 32'h2, 5'd1, 5'd0,
         mk(32'h4030D093, 32'h214, 32'h66, 32'h403, 32'h403, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1));
    // illegal: unknown opcode, OP funct7=1, JALR funct3=1
    send(32'hFFFFFFFF, 32'h218, 32'h1, 32'h2, 5'd0, 5'd0,
         mk(32'hFFFFFFFF, 32'h218, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    send(32'h022081B3, 32'h21C, 32'h1, 32'h2, 5'd1, 5'd2,
         mk(32'h022081B3, 32'h21C, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    send(32'h00009067, 32'h220, 32'h1, 32'h2, 5'd1, 5'd0,
         mk(32'h00009067, 32'h220, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));

    // load-use: one bubble, then accepted
    ex_is_load_i = 1'b1; ex_rd_i = 5'd1;
    inst_i = 32'h002081B3; inst_addr_i = 32'h300; rs1_data_i = 32'h10; rs2_data_i = 32'h20;
    in_valid_i = 1'b1;
    sb.push_back(mk(32'h002081B3, 32'h300, 32'h10, 32'h20, 32'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    check_val("lu_ready0", {31'd0, in_ready_o}, 32'd0);
    @(posedge clk); #1;
    ex_is_load_i = 1'b0;
    check_val("lu_bubble", {31'd0, out_valid_o}, 32'd0);
    @(negedge clk);
    check_val("lu_ready1", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    check_val("lu_capt", {31'd0, out_valid_o}, 32'd1);

    // backpressure: hold A for 3 cycles while B waits
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    send(32'h00500093, 32'h400, 32'h0, 32'h0, 5'd0, 5'd0,
         mk(32'h00500093, 32'h400, 32'd0, 32'd5, 32'd5, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1));
    inst_i = 32'h123452B7; inst_addr_i = 32'h404; in_valid_i = 1'b1;
    sb.push_back(mk(32'h123452B7, 32'h404, 32'd0, 32'h12345000, 32'h12345000, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("hold_valid", {31'd0, out_valid_o}, 32'd1);
      check_val("hold_ready", {31'd0, in_ready_o}, 32'd0);
      check_val("hold_inst", inst_o, 32'h00500093);
      check_val("hold_addr", inst_addr_o, 32'h400);
      check_val("hold_op2", op2_o, 32'd5);
      @(posedge clk); #1;
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    check_val("rel_ready", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    check_val("rel_next", inst_o, 32'h123452B7);

    // flush drops the incoming instruction
    inst_i = 32'h00500093; inst_addr_i = 32'h500; in_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    check_val("flush_valid", {31'd0, out_valid_o}, 32'd0);

    // reset while a bundle is held
    out_ready_i = 1'b0;
    send(32'h00500093, 32'h504, 32'h0, 32'h0, 5'd0, 5'd0,
         mk(32'h00500093, 32'h504, 32'd0, 32'd5, 32'd5, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1));
    check_val("prerst_valid", {31'd0, out_valid_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_valid", {31'd0, out_valid_o}, 32'd0);
    check_val("arst_inst", inst_o, 32'h0000_0013);
    check_val("arst_op2", op2_o, 32'd0);
    check_val("arst_wen", {31'd0, reg_wen_o}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready_i = 1'b1;
    send(32'h00001397, 32'h600, 32'h0, 32'h0, 5'd0, 5'd0,
         mk(32'h00001397, 32'h600, 32'h600, 32'h1000, 32'h1000, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1));
    repeat (3) @(posedge clk);
    #1;
    check_val("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
